// File: rtl/bram_delay_prog.sv
// rtl/bram_delay_prog.sv - runtime-programmable BRAM circular-buffer delay line
module bram_delay_prog #(
  parameter int WIDTH         = 32,
  parameter int MAX_DELAY     = 1024,
  parameter int LATENCY       = 2,
  parameter int DEFAULT_DELAY = MAX_DELAY,
  localparam int ADDR_BITS    = $clog2(MAX_DELAY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [ADDR_BITS:0]   delay,
  input  logic                 delay_load,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 busy
);

  localparam logic [ADDR_BITS:0]   MAX_D   = (ADDR_BITS+1)'(MAX_DELAY);
  localparam logic [ADDR_BITS:0]   MIN_D   = (ADDR_BITS+1)'(LATENCY + 1);
  localparam int                   RST_D_I = (DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY :
                                             ((DEFAULT_DELAY < LATENCY + 1) ? LATENCY + 1 : DEFAULT_DELAY);
  localparam logic [ADDR_BITS:0]   RST_D   = (ADDR_BITS+1)'(RST_D_I);
  localparam logic [ADDR_BITS-1:0] LAT_A   = ADDR_BITS'(LATENCY);
  localparam logic [1:0]           LAT_C   = 2'(LATENCY);

  // State describes what dout currently shows, so it trails an accepted load by one ce-cycle.
  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_SWITCH
  } state_t;

  function automatic logic [ADDR_BITS:0] clamp_delay(input logic [ADDR_BITS:0] v);
    logic [ADDR_BITS:0] c;
    c = v;
    if (v > MAX_D)      c = MAX_D;
    else if (v < MIN_D) c = MIN_D;
    return c;
  endfunction

  logic [WIDTH-1:0]     r_ram [MAX_DELAY];
  logic [WIDTH-1:0]     r_rd_data;
  logic [WIDTH-1:0]     w_tail;
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic [ADDR_BITS:0]   r_hist;
  logic [ADDR_BITS:0]   r_d;
  logic [1:0]           r_sw_cnt;
  logic [1:0]           w_sw_cnt_nxt;
  logic                 w_load;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_dout;

  assign w_load = ce & delay_load;

  // The read trails the write by D-LATENCY so the sample reaches dout exactly D ce-cycles late;
  // truncating r_d makes D=MAX_DELAY land on wr_ptr+LATENCY, never on wr_ptr itself.
  assign w_rd_addr = r_wr_ptr + LAT_A - ADDR_BITS'(r_d);

  // Buffer write and first read stage; the RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      r_ram[r_wr_ptr] <= din;
      r_rd_data       <= r_ram[w_rd_addr];
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] r_pipe;
      // Second read stage for the two-cycle RAM configuration.
      always_ff @(posedge clk) begin
        if (ce) r_pipe <= r_rd_data;
      end
      assign w_tail = r_pipe;
    end else begin : g_lat1
      assign w_tail = r_rd_data;
    end
  endgenerate

  // Next state: r_sw_cnt counts the outputs still owed to the old delay's pipeline contents.
  always_comb begin
    w_state_nxt  = r_state;
    w_sw_cnt_nxt = r_sw_cnt;
    if (ce) begin
      if (r_sw_cnt != 2'd0) begin
        w_state_nxt  = S_SWITCH;
        w_sw_cnt_nxt = r_sw_cnt - 2'd1;
      end else begin
        case (r_state)
          S_FILL:   w_state_nxt = (r_hist >= r_d) ? S_RUN : S_FILL;
          S_RUN:    w_state_nxt = S_RUN;
          S_SWITCH: w_state_nxt = (r_hist >= r_d) ? S_RUN : S_FILL;
          default:  w_state_nxt = S_FILL;
        endcase
      end
      if (w_load) w_sw_cnt_nxt = LAT_C;
    end
  end

  // Pointers, history, delay register, state and masked output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_hist   <= '0;
      r_d      <= RST_D;
      r_sw_cnt <= 2'd0;
      r_state  <= S_FILL;
      r_dout   <= '0;
    end else if (ce) begin
      r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (r_hist != MAX_D) r_hist <= r_hist + (ADDR_BITS+1)'(1);
      if (w_load) r_d <= clamp_delay(delay);
      r_sw_cnt <= w_sw_cnt_nxt;
      r_state  <= w_state_nxt;
      r_dout   <= (w_state_nxt == S_RUN) ? w_tail : '0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = (r_state == S_RUN);
  assign busy       = (r_state != S_RUN);

endmodule

// File: tb/tb_bram_delay_prog.sv
// tb/tb_bram_delay_prog.sv - self-checking bench for bram_delay_prog
module tb_bram_delay_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_ce, a_load, a_valid, a_busy;
  logic [10:0] a_delay;
  logic [31:0] a_din, a_dout;
  logic        b_rst_n, b_ce, b_load, b_valid, b_busy;
  logic [7:0]  b_delay;
  logic [15:0] b_din, b_dout;

  bram_delay_prog #(.WIDTH(32), .MAX_DELAY(1024), .LATENCY(2), .DEFAULT_DELAY(1024)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .ce(a_ce), .delay(a_delay), .delay_load(a_load),
    .din(a_din), .dout(a_dout), .dout_valid(a_valid), .busy(a_busy));

  bram_delay_prog #(.WIDTH(16), .MAX_DELAY(128), .LATENCY(1), .DEFAULT_DELAY(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .ce(b_ce), .delay(b_delay), .delay_load(b_load),
    .din(b_din), .dout(b_dout), .dout_valid(b_valid), .busy(b_busy));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: full sample history indexed by ce-cycle, current delay, last load index.
  int          m_k[2], m_d[2], m_last[2];
  bit          m_ev[2];
  int unsigned m_ed[2];
  int          m_lat[2] = '{2, 1};
  int          m_max[2] = '{1024, 128};
  int          m_def[2] = '{1024, 3};
  int unsigned m_hist[2][4096];

  typedef struct {
    int ph; int k; bit load; int dly; bit ev; int ed; bit eb;
  } vec_t;
  vec_t vt[24];

  function automatic int clampd(int p, int v);
    int c;
    c = (v > m_max[p]) ? m_max[p] : v;
    if (c < m_lat[p] + 1) c = m_lat[p] + 1;
    return c;
  endfunction

  task automatic model_reset(input int p);
    m_k[p] = 0; m_d[p] = clampd(p, m_def[p]); m_last[p] = -100000;
    m_ev[p] = 1'b0; m_ed[p] = 0;
  endtask

  task automatic model_edge(input int p, input bit rn, input bit ce, input bit ld,
                            input int dly, input int unsigned dv);
    if (!rn) model_reset(p);
    else if (ce) begin
      m_hist[p][m_k[p] % 4096] = dv;
      if (m_k[p] - m_last[p] <= m_lat[p]) begin
        m_ev[p] = 1'b0; m_ed[p] = 0;
      end else if (m_k[p] >= m_d[p]) begin
        m_ev[p] = 1'b1; m_ed[p] = m_hist[p][(m_k[p] - m_d[p]) % 4096];
      end else begin
        m_ev[p] = 1'b0; m_ed[p] = 0;
      end
      if (ld) begin
        m_d[p] = clampd(p, dly); m_last[p] = m_k[p];
      end
      m_k[p]++;
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0, a_rst_n, a_ce, a_load, int'(a_delay), a_din);
    model_edge(1, b_rst_n, b_ce, b_load, int'(b_delay), 32'(b_din));
    #1;
    cmp("a_valid", 32'(a_valid), 32'(m_ev[0]));
    cmp("a_dout",  a_dout,       m_ed[0]);
    cmp("a_busy",  32'(a_busy),  32'(!m_ev[0]));
    cmp("b_valid", 32'(b_valid), 32'(m_ev[1]));
    cmp("b_dout",  32'(b_dout),  m_ed[1]);
    cmp("b_busy",  32'(b_busy),  32'(!m_ev[1]));
  endtask

  task automatic ramp(input int p, input int ph, input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      bit ld;
      int dly;
      ld = 1'b0; dly = 0;
      foreach (vt[i]) if (vt[i].ph == ph && vt[i].k == k && vt[i].load) begin ld = 1'b1; dly = vt[i].dly; end
      if (p == 0) begin a_ce = 1'b1; a_din = 32'(k); a_load = ld; a_delay = 11'(dly); end
      else        begin b_ce = 1'b1; b_din = 16'(k); b_load = ld; b_delay = 8'(dly); end
      cyc();
      foreach (vt[i]) if (vt[i].ph == ph && vt[i].k == k) begin
        cmp($sformatf("tbl%0d_k%0d_valid", ph, k), (p == 0) ? 32'(a_valid) : 32'(b_valid), 32'(vt[i].ev));
        cmp($sformatf("tbl%0d_k%0d_dout", ph, k),  (p == 0) ? a_dout : 32'(b_dout),        32'(vt[i].ed));
        cmp($sformatf("tbl%0d_k%0d_busy", ph, k),  (p == 0) ? 32'(a_busy) : 32'(b_busy),   32'(vt[i].eb));
      end
    end
    a_load = 1'b0; b_load = 1'b0; a_ce = 1'b0; b_ce = 1'b0;
  endtask

  initial begin
    int en, rise;
    // phase, k, load, delay, exp valid, exp dout, exp busy
    vt[0]  = '{0, 0,    0, 0,    0, 0,    1};
    vt[1]  = '{0, 1023, 0, 0,    0, 0,    1};
    vt[2]  = '{0, 1024, 0, 0,    1, 0,    0};
    vt[3]  = '{0, 1500, 0, 0,    1, 476,  0};
    vt[4]  = '{0, 2000, 1, 5,    1, 976,  0};
    vt[5]  = '{0, 2001, 0, 0,    0, 0,    1};
    vt[6]  = '{0, 2002, 0, 0,    0, 0,    1};
    vt[7]  = '{0, 2003, 0, 0,    1, 1998, 0};
    vt[8]  = '{0, 2100, 0, 0,    1, 2095, 0};
    vt[9]  = '{0, 2200, 1, 0,    1, 2195, 0};
    vt[10] = '{0, 2203, 0, 0,    1, 2200, 0};
    vt[11] = '{0, 2300, 1, 2047, 1, 2297, 0};
    vt[12] = '{0, 2303, 0, 0,    1, 1279, 0};
    vt[13] = '{0, 2999, 0, 0,    1, 1975, 0};
    vt[14] = '{1, 1023, 0, 0,    0, 0,    1};
    vt[15] = '{1, 1024, 0, 0,    1, 0,    0};
    vt[16] = '{1, 1500, 0, 0,    1, 476,  0};
    vt[17] = '{2, 2,    0, 0,    0, 0,    1};
    vt[18] = '{2, 3,    0, 0,    1, 0,    0};
    vt[19] = '{2, 10,   1, 100,  1, 7,    0};
    vt[20] = '{2, 11,   0, 0,    0, 0,    1};
    vt[21] = '{2, 99,   0, 0,    0, 0,    1};
    vt[22] = '{2, 100,  0, 0,    1, 0,    0};
    vt[23] = '{2, 140,  0, 0,    1, 40,   0};

    a_rst_n = 1'b0; a_ce = 1'b0; a_load = 1'b0; a_delay = '0; a_din = '0;
    b_rst_n = 1'b0; b_ce = 1'b0; b_load = 1'b0; b_delay = '0; b_din = '0;
    model_reset(0); model_reset(1);
    repeat (3) cyc();
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Fill, shrink, clamp low/high on the default-sized instance.
    ramp(0, 0, 3000);

    // Asynchronous reset between edges, then the fill must repeat exactly.
    #2 a_rst_n = 1'b0;
    #1;
    cmp("async_rst_dout",  a_dout,       32'd0);
    cmp("async_rst_valid", 32'(a_valid), 32'd0);
    cmp("async_rst_busy",  32'(a_busy),  32'd1);
    repeat (3) cyc();
    a_rst_n = 1'b1;
    ramp(0, 1, 1500);

    // Grow the delay beyond the available history.
    b_rst_n = 1'b0;
    repeat (2) cyc();
    b_rst_n = 1'b1;
    ramp(1, 2, 140);

    // Alternating ce with delay 8 loaded on the first enabled edge.
    b_rst_n = 1'b0;
    repeat (2) cyc();
    b_rst_n = 1'b1;
    en = 0; rise = -1;
    for (int n = 0; n < 40; n++) begin
      b_ce = (n % 2 == 0); b_load = (n == 0); b_delay = 8'd8; b_din = 16'($urandom);
      cyc();
      if (b_ce) en++;
      if (rise < 0 && b_valid === 1'b1) rise = en;
    end
    b_load = 1'b0;
    cmp("ce50_rise_edge", 32'(rise), 32'd9);

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 4000; n++) begin
      a_ce = ($urandom_range(0, 3) != 0); a_load = ($urandom_range(0, 40) == 0);
      a_delay = 11'($urandom_range(0, 2047)); a_din = $urandom;
      b_ce = ($urandom_range(0, 3) != 0); b_load = ($urandom_range(0, 30) == 0);
      b_delay = 8'($urandom_range(0, 255)); b_din = 16'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
